// File: rtl/acia_baud_gen.sv
// ---------------------------------------------------------------------------
// acia_baud_gen
//   Baud-rate strobe generator for an ACIA. A transmit divisor counter
//   produces an oversample strobe every D XTLI cycles, where D comes from a
//   16-entry rate table or from DIV_CUSTOM. A phase counter divides that
//   strobe by OVS to mark bit boundaries. The receive side can share the
//   transmit divisor (RCS=0) or run its own (RCS=1). Its phase can be
//   re-aligned to a start-bit edge with RX_SYNC, so that RX_BIT lands
//   mid-bit.
//
//   Strobes are registered. A strobe is visible in the cycle after the edge
//   at which its divisor counter was sampled at zero. RX_SYNC is sampled on
//   that same edge, so an RX_SYNC high in the cycle before RX_CE16 goes high
//   "coincides" with that RX_CE16.
//
// Parameters
//   CNT_W       divisor counter width (12..24)
//   OVS         oversample factor, power of two 2..64
// Ports
//   XTLI        clock, rising edge
//   RESET       asynchronous active-low reset
//   TX_SBR      transmit rate select (0000 = DIV_CUSTOM)
//   RX_SBR      receive rate select, used when RCS=1
//   RCS         0: RX shares the TX divisor, 1: RX has its own divisor
//   DIV_CUSTOM  divisor used for rate code 0000 (0 or 1 = every cycle)
//   RX_SYNC     one-cycle start-edge pulse, re-phases the RX side
//   TX_CE16     TX oversample strobe
//   RX_CE16     RX oversample strobe
//   TX_BIT      TX bit-boundary strobe
//   RX_BIT      RX mid-bit sample strobe
//   TX_BCLK     square wave toggling on every TX_CE16
// ---------------------------------------------------------------------------
module acia_baud_gen #(
  parameter int CNT_W = 16,
  parameter int OVS   = 16
) (
  input  logic             XTLI,
  input  logic             RESET,
  input  logic [3:0]       TX_SBR,
  input  logic [3:0]       RX_SBR,
  input  logic             RCS,
  input  logic [CNT_W-1:0] DIV_CUSTOM,
  input  logic             RX_SYNC,
  output logic             TX_CE16,
  output logic             RX_CE16,
  output logic             TX_BIT,
  output logic             RX_BIT,
  output logic             TX_BCLK
);

  localparam int               PW      = $clog2(OVS);
  localparam logic [PW-1:0]    PH_LAST = PW'(OVS - 1);
  localparam logic [PW-1:0]    PH_MID  = PW'(OVS / 2);
  localparam logic [PW-1:0]    PH_ONE  = PW'(1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  // Rate table. Constants are held at 24 bits and truncated to the counter
  // width, so narrow counters silently wrap large divisors.
  function automatic logic [CNT_W-1:0] rate_div(input logic [3:0]       sbr,
                                                input logic [CNT_W-1:0] custom);
    logic [23:0] tbl;
    case (sbr)
      4'h1:    tbl = 24'd2304;
      4'h2:    tbl = 24'd1536;
      4'h3:    tbl = 24'd1048;
      4'h4:    tbl = 24'd856;
      4'h5:    tbl = 24'd768;
      4'h6:    tbl = 24'd384;
      4'h7:    tbl = 24'd192;
      4'h8:    tbl = 24'd96;
      4'h9:    tbl = 24'd64;
      4'hA:    tbl = 24'd48;
      4'hB:    tbl = 24'd32;
      4'hC:    tbl = 24'd24;
      4'hD:    tbl = 24'd16;
      4'hE:    tbl = 24'd12;
      4'hF:    tbl = 24'd6;
      default: tbl = 24'd0;
    endcase
    if (sbr == 4'h0) rate_div = custom;
    else             rate_div = tbl[CNT_W-1:0];
  endfunction

  // Reload value D-1. A divisor of 0 or 1 reloads 0, so the counter sits at
  // zero and strobes every cycle.
  function automatic logic [CNT_W-1:0] reload_val(input logic [CNT_W-1:0] d);
    if (d <= ONE) reload_val = '0;
    else          reload_val = d - ONE;
  endfunction

  logic [CNT_W-1:0] tx_cnt_reg, tx_cnt_next;
  logic [CNT_W-1:0] rx_cnt_reg, rx_cnt_next;
  logic [PW-1:0]    tx_ph_reg,  tx_ph_next;
  logic [PW-1:0]    rx_ph_reg,  rx_ph_next;
  logic             rcs_reg,    rcs_next;
  logic             tx_ce_reg,  rx_ce_reg;
  logic             tx_bit_reg, rx_bit_reg;
  logic             bclk_reg,   bclk_next;
  logic             tx_tick,    rx_tick;
  logic             tx_wrap,    rx_wrap;

  always_comb begin
    tx_tick = (tx_cnt_reg == '0);
    // The RX source in use for this cycle follows the registered RCS. The
    // registered RCS only changes on a TX reload.
    rx_tick = rcs_reg ? (rx_cnt_reg == '0) : tx_tick;
    rcs_next = tx_tick ? RCS : rcs_reg;

    tx_wrap = tx_tick && (tx_ph_reg == PH_LAST);
    // RX_SYNC overrides the wrap: no RX_BIT, the phase is re-centred instead.
    rx_wrap = rx_tick && (rx_ph_reg == PH_LAST) && !RX_SYNC;

    // Rate selects are only looked at here, on the reload edge. A rate
    // change therefore never shortens the period already in progress.
    tx_cnt_next = tx_tick ? reload_val(rate_div(TX_SBR, DIV_CUSTOM))
                          : tx_cnt_reg - ONE;

    // The RX counter is held at zero whenever RX shares the TX divisor.
    // Holding it at zero means it reloads on its first edge after RCS rises.
    if (!rcs_next) begin
      rx_cnt_next = '0;
    end else if (RX_SYNC || rx_tick) begin
      rx_cnt_next = reload_val(rate_div(RX_SBR, DIV_CUSTOM));
    end else begin
      rx_cnt_next = rx_cnt_reg - ONE;
    end

    tx_ph_next = tx_tick ? tx_ph_reg + PH_ONE : tx_ph_reg;

    if (RX_SYNC)      rx_ph_next = PH_MID;
    else if (rx_tick) rx_ph_next = rx_ph_reg + PH_ONE;
    else              rx_ph_next = rx_ph_reg;

    bclk_next = tx_tick ? ~bclk_reg : bclk_reg;
  end

  always_ff @(posedge XTLI or negedge RESET) begin
    if (!RESET) begin
      tx_cnt_reg <= '0;
      rx_cnt_reg <= '0;
      tx_ph_reg  <= '0;
      rx_ph_reg  <= '0;
      rcs_reg    <= 1'b0;
      tx_ce_reg  <= 1'b0;
      rx_ce_reg  <= 1'b0;
      tx_bit_reg <= 1'b0;
      rx_bit_reg <= 1'b0;
      bclk_reg   <= 1'b0;
    end else begin
      tx_cnt_reg <= tx_cnt_next;
      rx_cnt_reg <= rx_cnt_next;
      tx_ph_reg  <= tx_ph_next;
      rx_ph_reg  <= rx_ph_next;
      rcs_reg    <= rcs_next;
      tx_ce_reg  <= tx_tick;
      rx_ce_reg  <= rx_tick;
      tx_bit_reg <= tx_wrap;
      rx_bit_reg <= rx_wrap;
      bclk_reg   <= bclk_next;
    end
  end

  assign TX_CE16 = tx_ce_reg;
  assign RX_CE16 = rx_ce_reg;
  assign TX_BIT  = tx_bit_reg;
  assign RX_BIT  = rx_bit_reg;
  assign TX_BCLK = bclk_reg;

endmodule

// File: tb/tb_acia_baud_gen.sv
// ---------------------------------------------------------------------------
// tb_acia_baud_gen
//   Self-checking bench for acia_baud_gen. Expected strobe intervals are
//   queued when a configuration is applied. A pulse monitor pops one entry
//   per observed strobe and compares it with the measured interval.
// ---------------------------------------------------------------------------
module tb_acia_baud_gen;

  localparam int CNT_W = 16;
  localparam int OVS   = 16;

  localparam int S_TXCE  = 0;
  localparam int S_RXCE  = 1;
  localparam int S_TXBIT = 2;
  localparam int S_RXBIT = 3;
  localparam int S_BCLK  = 4;

  logic             XTLI       = 1'b0;
  logic             RESET      = 1'b0;
  logic [3:0]       TX_SBR     = 4'hF;
  logic [3:0]       RX_SBR     = 4'hF;
  logic             RCS        = 1'b0;
  logic [CNT_W-1:0] DIV_CUSTOM = '0;
  logic             RX_SYNC    = 1'b0;
  logic             TX_CE16, RX_CE16, TX_BIT, RX_BIT, TX_BCLK;

  int cyc        = 0;
  int n_checks   = 0;
  int n_fail     = 0;
  int last_pulse = -1;
  int exp_q[$];

  acia_baud_gen #(.CNT_W(CNT_W), .OVS(OVS)) dut (
    .XTLI       (XTLI),
    .RESET      (RESET),
    .TX_SBR     (TX_SBR),
    .RX_SBR     (RX_SBR),
    .RCS        (RCS),
    .DIV_CUSTOM (DIV_CUSTOM),
    .RX_SYNC    (RX_SYNC),
    .TX_CE16    (TX_CE16),
    .RX_CE16    (RX_CE16),
    .TX_BIT     (TX_BIT),
    .RX_BIT     (RX_BIT),
    .TX_BCLK    (TX_BCLK)
  );

  always #5 XTLI = ~XTLI;

  // Number of rising edges so far; read on falling edges only.
  always @(posedge XTLI) cyc <= cyc + 1;

  task automatic check_value(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end else begin
      $display("ok   %s: %0d (cycle %0d)", tag, obs, cyc);
    end
  endtask

  task automatic expect_n(input int val, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(val);
  endtask

  function automatic logic pick(input int which, input logic prev_bclk);
    case (which)
      S_TXCE:  pick = TX_CE16;
      S_RXCE:  pick = RX_CE16;
      S_TXBIT: pick = TX_BIT;
      S_RXBIT: pick = RX_BIT;
      default: pick = TX_BCLK && !prev_bclk;
    endcase
  endfunction

  // Measures the spacing of a strobe until the expectation queue drains.
  // With ref_cyc >= 0 the first interval is taken from ref_cyc. Otherwise
  // the first pulse only sets the reference. An exhausted budget counts
  // as one failed comparison.
  task automatic run_pulses(input int which, input string tag,
                            input int ref_cyc, input int budget);
    int   last   = ref_cyc;
    int   waited = 0;
    logic prev_b = TX_BCLK;
    while (exp_q.size() > 0 && waited < budget) begin
      @(negedge XTLI);
      waited++;
      if (pick(which, prev_b)) begin
        if (last >= 0) check_value(tag, cyc - last, exp_q.pop_front());
        last = cyc;
        last_pulse = cyc;
      end
      prev_b = TX_BCLK;
    end
    if (exp_q.size() > 0) begin
      check_value({tag, " timeout, pulses left"}, exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  // Holds reset for a few edges, checks the outputs are idle, releases on a
  // falling edge and returns the edge count at release.
  task automatic apply_reset(output int rel);
    @(negedge XTLI);
    RESET = 1'b0;
    repeat (3) @(negedge XTLI);
    check_value("outputs in reset",
                int'({TX_CE16, RX_CE16, TX_BIT, RX_BIT, TX_BCLK}), 0);
    RESET = 1'b1;
    rel = cyc;
  endtask

  // RX_SYNC is high for exactly one cycle. It is sampled on the edge whose
  // count is returned.
  task automatic pulse_sync(output int s);
    RX_SYNC = 1'b1;
    @(negedge XTLI);
    RX_SYNC = 1'b0;
    s = cyc;
  endtask

  initial begin
    int rel;
    int s;
    int mism;
    int cnt;
    int guard;
    int found;

    // Rate F, shared RX: first strobe on the first edge, then every 6.
    apply_reset(rel);
    expect_n(1, 1);
    expect_n(6, 4);
    run_pulses(S_TXCE, "tx_ce16 rate F", rel, 200);

    // First TX_BIT on the 16th strobe (1 + 15*6), then every 96.
    apply_reset(rel);
    expect_n(91, 1);
    expect_n(96, 2);
    run_pulses(S_TXBIT, "tx_bit rate F", rel, 400);

    // RX follows TX exactly when RCS=0.
    mism = 0;
    cnt  = 0;
    for (int i = 0; i < 96; i++) begin
      @(negedge XTLI);
      if (RX_CE16 !== TX_CE16) mism++;
      if (TX_CE16) cnt++;
    end
    check_value("rx_ce16 vs tx_ce16 differing cycles", mism, 0);
    check_value("tx_ce16 pulses per 96 cycles", cnt, 16);

    expect_n(12, 3);
    run_pulses(S_BCLK, "tx_bclk period", -1, 100);

    // Custom divisor: 1 and 0 both strobe every cycle; 5 gives period 5.
    TX_SBR     = 4'h0;
    DIV_CUSTOM = 16'd1;
    apply_reset(rel);
    expect_n(1, 5);
    run_pulses(S_TXCE, "tx_ce16 custom 1", rel, 20);
    DIV_CUSTOM = 16'd0;
    rel = cyc;
    expect_n(1, 4);
    run_pulses(S_TXCE, "tx_ce16 custom 0", rel, 20);
    DIV_CUSTOM = 16'd5;
    rel = cyc;
    expect_n(1, 1);
    expect_n(5, 3);
    run_pulses(S_TXCE, "tx_ce16 custom 5", rel, 40);

    // Rate E to 8 mid-period: the running 12-cycle interval completes.
    TX_SBR = 4'hE;
    apply_reset(rel);
    expect_n(1, 1);
    expect_n(12, 1);
    run_pulses(S_TXCE, "tx_ce16 rate E", rel, 40);
    rel = last_pulse;
    repeat (5) @(negedge XTLI);
    TX_SBR = 4'h8;
    expect_n(12, 1);
    expect_n(96, 2);
    run_pulses(S_TXCE, "tx_ce16 E->8 switch", rel, 400);

    // Independent RX divisor.
    TX_SBR = 4'hE;
    RX_SBR = 4'hF;
    RCS    = 1'b1;
    apply_reset(rel);
    expect_n(1, 1);
    expect_n(12, 3);
    run_pulses(S_TXCE, "tx_ce16 rcs=1 rate E", rel, 100);
    expect_n(6, 4);
    run_pulses(S_RXCE, "rx_ce16 rcs=1 rate F", -1, 100);

    // RX_SYNC: RX_BIT 8 strobes (48 cycles) later, then every 96.
    pulse_sync(s);
    expect_n(48, 1);
    expect_n(96, 2);
    run_pulses(S_RXBIT, "rx_bit after sync", s, 400);

    // Sync on the edge that would have produced the next RX_BIT.
    rel   = last_pulse;
    guard = 0;
    while (cyc < rel + 95 && guard < 300) begin
      @(negedge XTLI);
      guard++;
    end
    pulse_sync(s);
    check_value("rx_bit on coincident sync", int'(RX_BIT), 0);
    check_value("rx_ce16 on coincident sync", int'(RX_CE16), 1);
    expect_n(48, 1);
    run_pulses(S_RXBIT, "rx_bit after coincident sync", s, 200);

    // Asynchronous reset while a strobe is high, mid-count.
    found = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge XTLI);
      if (TX_CE16) begin
        found = 1;
        break;
      end
    end
    check_value("tx_ce16 seen before async reset", found, 1);
    #2;
    RESET = 1'b0;
    #1;
    check_value("outputs right after async reset",
                int'({TX_CE16, RX_CE16, TX_BIT, RX_BIT, TX_BCLK}), 0);
    repeat (2) @(negedge XTLI);
    RESET = 1'b1;
    rel = cyc;
    expect_n(1, 1);
    expect_n(12, 2);
    run_pulses(S_TXCE, "tx_ce16 after async reset", rel, 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/acia_baud_gen.md
ACIA_BAUD_GEN -- requirements
Module: acia_baud_gen

Interface
REQ-001 The parameter CNT_W SHALL default to 16 and set the divisor counter width; legal values are 12..24.
REQ-002 The parameter OVS SHALL default to 16 and set the oversample factor; it is a power of two from 2 to 64.
REQ-003 Port XTLI SHALL be an input, 1 bit: the single clock, all logic on the rising edge.
REQ-004 Port RESET SHALL be an input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port TX_SBR SHALL be an input, 4 bits: transmit rate select.
REQ-006 Port RX_SBR SHALL be an input, 4 bits: receive rate select, used only when RCS=1.
REQ-007 Port RCS SHALL be an input, 1 bit: 0 makes RX share the TX generator, 1 gives RX its own generator.
REQ-008 Port DIV_CUSTOM SHALL be an input, CNT_W bits: the divisor used when a rate select is 0000.
REQ-009 Port RX_SYNC SHALL be an input, 1 bit: a one-cycle start-bit-edge pulse that re-phases RX.
REQ-010 Port TX_CE16 SHALL be an output, 1 bit: a one-cycle TX oversample strobe.
REQ-011 Port RX_CE16 SHALL be an output, 1 bit: a one-cycle RX oversample strobe.
REQ-012 Port TX_BIT SHALL be an output, 1 bit: a one-cycle TX bit-boundary strobe.
REQ-013 Port RX_BIT SHALL be an output, 1 bit: a one-cycle RX mid-bit sample strobe.
REQ-014 Port TX_BCLK SHALL be an output, 1 bit: a registered square wave toggling on each TX_CE16.

Function
REQ-015 Divisor D, in XTLI cycles per CE16, SHALL be selected by rate code: 0000 gives DIV_CUSTOM, 1 gives 2304, 2 gives 1536, 3 gives 1048, 4 gives 856, 5 gives 768, 6 gives 384, 7 gives 192, 8 gives 96, 9 gives 64, A gives 48, B gives 32, C gives 24, D gives 16, E gives 12, F gives 6.
REQ-016 A DIV_CUSTOM value of 0 or 1 SHALL make CE16 assert on every cycle.
REQ-017 Each generator SHALL be a down-counter that asserts CE16 in the cycle it equals 0 and then reloads D-1, giving a CE16 period of exactly D cycles.
REQ-018 Changes to a rate select or to DIV_CUSTOM SHALL be sampled only at reload, so the current period always completes with no short or glitched strobe.
REQ-019 The TX phase counter (log2(OVS) bits) SHALL increment on each TX_CE16, and TX_BIT SHALL assert together with the TX_CE16 on which the counter wraps from OVS-1 to 0.
REQ-020 The RX phase counter SHALL increment on each RX_CE16, and RX_BIT SHALL assert together with the RX_CE16 on which the counter wraps.
REQ-021 When RCS=0, RX_CE16 SHALL equal TX_CE16 and the RX divisor counter SHALL be held at 0, while the RX phase counter stays independent.
REQ-022 When RCS=1, RX SHALL use its own divisor counter driven by RX_SBR.
REQ-023 A change of RCS SHALL take effect at the next TX reload.
REQ-024 RX_SYNC SHALL load the RX phase counter with OVS/2 and, when RCS=1, reload the RX divisor counter with D-1, so that RX_BIT asserts OVS/2 CE16 periods after the sync.
REQ-025 If RX_SYNC coincides with RX_CE16, RX_SYNC SHALL win: no RX_BIT is issued that cycle and the phase counter is loaded with OVS/2.
REQ-026 All outputs SHALL be registered, or decoded from counter==0 in a registered form, so that strobes are exactly one XTLI cycle wide.
REQ-027 Divisor arithmetic SHALL be unsigned CNT_W-bit, and table constants SHALL be truncated to CNT_W bits with no error flagged.

Reset
REQ-028 While RESET=0, both divisor counters SHALL be 0, both phase counters 0, and TX_CE16, RX_CE16, TX_BIT, RX_BIT and TX_BCLK all 0.
REQ-029 After RESET releases, the first TX_CE16 SHALL occur on the first rising edge of XTLI and then every D cycles.
REQ-030 The first TX_BIT SHALL occur on the OVS-th TX_CE16.
REQ-031 Reset asserted mid-count SHALL clear all state immediately, without waiting for a clock edge.

Verification
REQ-032 With TX_SBR=F, RCS=0 and OVS=16, the bench SHALL check that TX_CE16 pulses every 6 cycles, that TX_BIT pulses every 96 cycles, that RX_CE16 equals TX_CE16, and that TX_BCLK has a 12-cycle period.
REQ-033 With TX_SBR=0, DIV_CUSTOM=1 and then DIV_CUSTOM=5, the bench SHALL check that CE16 asserts every cycle, and that after the next reload it asserts every 5 cycles.
REQ-034 Switching TX_SBR from E to 8 mid-period SHALL complete the current 12-cycle interval before the intervals become 96 cycles, with no strobe spacing under 12.
REQ-035 With RCS=1, TX_SBR=E and RX_SBR=F, the bench SHALL check that TX_CE16 has period 12 and RX_CE16 has period 6, independently.
REQ-036 With RCS=1 and RX_SBR=F, an RX_SYNC pulse SHALL produce RX_BIT 48 cycles later and every 96 cycles after that.
REQ-037 For an RX_SYNC issued in the same cycle as RX_CE16, the bench SHALL check that no RX_BIT occurs in that cycle.
REQ-038 Asserting RESET at a counter midpoint SHALL drive all outputs to 0 asynchronously.
REQ-039 After the reset in REQ-038 releases, the bench SHALL check that the first TX_CE16 occurs on the first XTLI edge.
